// File: rtl/audio_wb_dma_reader_pkg.sv
// Shared audio definitions: DMA reader FSM encoding, frame geometry and the
// audio_data field layout also used by the audio register file.
package audio_wb_dma_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_L,
      ST_WAIT_L,
      ST_REQ_R,
      ST_WAIT_R,
      ST_PUSH,
      ST_DONE
   } dma_state_t;

   localparam logic [31:0] FRAME_STRIDE = 32'd8;
   localparam logic [31:0] CHAN_OFFSET  = 32'd4;

   localparam int SAMPLE_W      = 24;
   localparam int AUD_LEFT_LSB  = 0;
   localparam int AUD_RIGHT_LSB = SAMPLE_W;
   localparam int AUD_DATA_W    = 2 * SAMPLE_W;

   function automatic logic [AUD_DATA_W-1:0] pack_frame(input logic [SAMPLE_W-1:0] left,
                                                        input logic [SAMPLE_W-1:0] right);
      logic [AUD_DATA_W-1:0] f;
      f = '0;
      f[AUD_LEFT_LSB  +: SAMPLE_W] = left;
      f[AUD_RIGHT_LSB +: SAMPLE_W] = right;
      return f;
   endfunction

endpackage

// File: rtl/audio_wb_dma_reader_watchdog.sv
// Bus response watchdog: loaded when a strobe is accepted, counts down while
// waiting for ack/err. TIMEOUT_CYCLES = 0 never expires.
module audio_wb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = CW'(TIMEOUT_CYCLES);
      else if (enable_i && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // Fires on the last permitted wait cycle, so the wait lasts exactly TIMEOUT_CYCLES.
   assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == CW'(1));

endmodule

// File: rtl/audio_wb_dma_reader.sv
// Wishbone pipelined read initiator: fetches {left,right} sample words per
// frame and pushes them into the audio FIFO in place of CPU register writes.
module audio_wb_dma_reader
   import audio_wb_dma_reader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned FRAME_CNT_BITS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      loop_en,
   input  logic [31:0]               base_addr,
   input  logic [FRAME_CNT_BITS-1:0] num_frames,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [FRAME_CNT_BITS-1:0] frames_done,
   output logic [31:0]               wbm_adr_o,
   input  logic [31:0]               wbm_dat_i,
   output logic [3:0]                wbm_sel_o,
   output logic                      wbm_we_o,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   input  logic                      wbm_stall_i,
   input  logic                      wbm_ack_i,
   input  logic                      wbm_err_i,
   output logic [AUD_DATA_W-1:0]     audio_data,
   output logic                      audio_valid,
   input  logic                      fifo_ready
);

   dma_state_t                state_q, state_d;
   logic [31:0]               cur_q, cur_d;
   logic [FRAME_CNT_BITS-1:0] num_q, num_d;
   logic [FRAME_CNT_BITS-1:0] fdone_q, fdone_d;
   logic [SAMPLE_W-1:0]       left_q, left_d;
   logic [SAMPLE_W-1:0]       right_q, right_d;
   logic                      err_q, err_d;
   logic                      abort_pend_q, abort_pend_d;
   logic                      gap_q, gap_d;

   logic                      pend;
   logic                      last_frame;
   logic [FRAME_CNT_BITS-1:0] fdone_inc;
   logic [31:0]               base_aligned;
   logic                      wd_load, wd_en, wd_expired;
   logic                      unused_dat;

   assign pend         = abort | abort_pend_q;
   assign fdone_inc    = fdone_q + FRAME_CNT_BITS'(1);
   assign last_frame   = (fdone_inc == num_q);
   assign base_aligned = {base_addr[31:2], 2'b00};
   assign unused_dat   = ^wbm_dat_i[31:SAMPLE_W];

   audio_wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wd (
      .clk       (clk),
      .rst       (rst),
      .load_i    (wd_load),
      .enable_i  (wd_en),
      .expired_o (wd_expired)
   );

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      num_d        = num_q;
      fdone_d      = fdone_q;
      left_d       = left_q;
      right_d      = right_q;
      err_d        = err_q;
      abort_pend_d = (state_q == ST_IDLE) ? 1'b0 : pend;
      gap_d        = 1'b0;
      wbm_cyc_o    = 1'b0;
      wbm_stb_o    = 1'b0;
      wbm_adr_o    = '0;
      audio_valid  = 1'b0;
      wd_load      = 1'b0;
      wd_en        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_frames != '0) begin
                  cur_d   = base_aligned;
                  num_d   = num_frames;
                  err_d   = 1'b0;
                  fdone_d = '0;
                  state_d = ST_REQ_L;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         // Only safe abort point on the bus side: nothing has been accepted yet.
         ST_REQ_L: begin
            wbm_adr_o = cur_q;
            if (pend) begin
               state_d = ST_DONE;
            end else begin
               wbm_cyc_o = 1'b1;
               wbm_stb_o = 1'b1;
               if (!wbm_stall_i) begin
                  wd_load = 1'b1;
                  state_d = ST_WAIT_L;
               end
            end
         end

         ST_WAIT_L: begin
            wbm_cyc_o = 1'b1;
            wbm_adr_o = cur_q;
            wd_en     = 1'b1;
            if (wbm_err_i) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (wbm_ack_i) begin
               left_d  = wbm_dat_i[SAMPLE_W-1:0];
               gap_d   = 1'b1;
               state_d = ST_REQ_R;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end

         // First cycle after the left ack is a bus-idle gap (cyc low).
         ST_REQ_R: begin
            wbm_adr_o = cur_q + CHAN_OFFSET;
            if (!gap_q) begin
               wbm_cyc_o = 1'b1;
               wbm_stb_o = 1'b1;
               if (!wbm_stall_i) begin
                  wd_load = 1'b1;
                  state_d = ST_WAIT_R;
               end
            end
         end

         ST_WAIT_R: begin
            wbm_cyc_o = 1'b1;
            wbm_adr_o = cur_q + CHAN_OFFSET;
            wd_en     = 1'b1;
            if (wbm_err_i) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (wbm_ack_i) begin
               right_d = wbm_dat_i[SAMPLE_W-1:0];
               state_d = pend ? ST_DONE : ST_PUSH;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_PUSH: begin
            if (fifo_ready) begin
               audio_valid = 1'b1;
               cur_d       = cur_q + FRAME_STRIDE;
               fdone_d     = fdone_inc;
               if (!last_frame) begin
                  state_d = ST_REQ_L;
               end else if (loop_en) begin
                  cur_d   = base_aligned;
                  fdone_d = '0;
                  state_d = ST_REQ_L;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cur_q        <= '0;
         num_q        <= '0;
         fdone_q      <= '0;
         left_q       <= '0;
         right_q      <= '0;
         err_q        <= 1'b0;
         abort_pend_q <= 1'b0;
         gap_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         num_q        <= num_d;
         fdone_q      <= fdone_d;
         left_q       <= left_d;
         right_q      <= right_d;
         err_q        <= err_d;
         abort_pend_q <= abort_pend_d;
         gap_q        <= gap_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign error       = err_q;
   assign frames_done = fdone_q;
   assign audio_data  = pack_frame(left_q, right_q);
   assign wbm_sel_o   = 4'hF;
   assign wbm_we_o    = 1'b0;

endmodule

// File: tb/tb_audio_wb_dma_reader.sv
// Directed bench: memory/slave model, scoreboard queue of expected pushes and
// a negedge monitor that pops and compares on every audio_valid.
module tb_audio_wb_dma_reader;

   localparam int FCB = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0, abort = 1'b0, loop_en = 1'b0, fifo_ready = 1'b1;
   logic [31:0]    base_addr = '0;
   logic [FCB-1:0] num_frames = '0;
   logic           busy, done, error;
   logic [FCB-1:0] frames_done;
   logic [31:0]    wbm_adr_o, wbm_dat_i;
   logic [3:0]     wbm_sel_o;
   logic           wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_stall_i, wbm_ack_i, wbm_err_i;
   logic [47:0]    audio_data;
   logic           audio_valid;

   always #5 clk = ~clk;

   audio_wb_dma_reader #(.TIMEOUT_CYCLES(8), .FRAME_CNT_BITS(FCB)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
      .base_addr(base_addr), .num_frames(num_frames), .busy(busy), .done(done),
      .error(error), .frames_done(frames_done), .wbm_adr_o(wbm_adr_o),
      .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_stall_i(wbm_stall_i),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .audio_data(audio_data),
      .audio_valid(audio_valid), .fifo_ready(fifo_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // ---------------- memory / Wishbone slave model ----------------
   logic [31:0] mem [int unsigned];
   int          stall_req = 0, ack_delay = 0;
   bit          no_ack = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFFC, exp_stall_adr = 32'h1000;
   int          stall_done = 0, reads = 0, stall_adr_bad = 0, cyc_drop_bad = 0;
   logic        pend = 1'b0, ack_r = 1'b0, err_r = 1'b0;
   logic [31:0] dat_r = '0, lat_adr = '0;
   int          dly = 0;
   logic        accept, go;
   logic [31:0] go_adr;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hDEAD_BEEF;
   endfunction

   assign wbm_stall_i = wbm_cyc_o && wbm_stb_o && (stall_done < stall_req);
   assign accept      = wbm_cyc_o && wbm_stb_o && !wbm_stall_i;
   assign go          = (pend && dly == 0) || (accept && ack_delay == 0);
   assign go_adr      = (pend && dly == 0) ? lat_adr : wbm_adr_o;
   assign wbm_ack_i   = ack_r;
   assign wbm_err_i   = err_r;
   assign wbm_dat_i   = dat_r;

   always @(posedge clk) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (!rst) begin
         pend <= 1'b0;
      end else begin
         if (wbm_stall_i) begin
            stall_done <= stall_done + 1;
            if (wbm_adr_o != exp_stall_adr) stall_adr_bad <= stall_adr_bad + 1;
         end
         if ((pend || ack_r) && !wbm_cyc_o) cyc_drop_bad <= cyc_drop_bad + 1;
         if (go && !no_ack) begin
            if (go_adr == err_addr) err_r <= 1'b1;
            else begin
               ack_r <= 1'b1;
               dat_r <= rd(go_adr);
            end
         end
         if (pend) begin
            if (dly == 0) pend <= 1'b0;
            else          dly  <= dly - 1;
         end
         if (accept) begin
            reads <= reads + 1;
            if (ack_delay != 0) begin
               pend    <= 1'b1;
               dly     <= ack_delay - 1;
               lat_adr <= wbm_adr_o;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic [47:0] exp_q[$];
   int          valid_cnt = 0, done_cnt = 0, stb_cycles = 0, wait_cycles = 0;
   int          vcyc [256];

   initial begin
      forever begin
         @(negedge clk);
         if (audio_valid) begin
            vcyc[valid_cnt % 256] = cyc_n;
            valid_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_push: got %0h expected no push", audio_data);
            end else begin
               check("audio_data", audio_data, exp_q.pop_front());
            end
         end
         if (done) done_cnt++;
         if (wbm_stb_o) stb_cycles++;
         if (wbm_cyc_o && !wbm_stb_o) wait_cycles++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != d0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no done pulse expected one within %0d cycles", name, budget);
      end
   endtask

   int d0, r0, v0, s0, w0, t0;

   initial begin
      mem[32'h1000] = 32'h00AA_BBCC;
      mem[32'h1004] = 32'h0011_2233;
      mem[32'h1008] = 32'h0000_0001;
      mem[32'h100C] = 32'h0000_0002;

      // Reset state
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_frames_done", frames_done, 0);
      check("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
      check("rst_adr", wbm_adr_o, 0);
      check("rst_audio", {audio_valid, audio_data}, 0);
      rst = 1'b1;
      tick();

      // Two frames, zero wait
      base_addr = 32'h1000; num_frames = 2;
      d0 = done_cnt; r0 = reads; v0 = valid_cnt;
      exp_q.push_back(48'h112233_AABBCC);
      exp_q.push_back(48'h000002_000001);
      t0 = cyc_n;
      pulse_start();
      wait_done("two_frames", d0, 60);
      repeat (3) tick();
      check("latency", vcyc[v0 % 256] - t0, 6);
      check("two_pushes", valid_cnt - v0, 2);
      check("two_reads", reads - r0, 4);
      check("one_done", done_cnt - d0, 1);
      check("frames_done_2", frames_done, 2);
      check("busy_after", busy, 0);
      check("no_error", error, 0);
      check("sel_we", {wbm_sel_o, wbm_we_o}, 5'b11110);

      // Stall on the first request
      num_frames = 1; exp_stall_adr = 32'h1000;
      d0 = done_cnt; r0 = reads; v0 = valid_cnt; s0 = stb_cycles;
      stall_req = stall_done + 3;
      exp_q.push_back(48'h112233_AABBCC);
      pulse_start();
      wait_done("stall", d0, 60);
      check("stall_stb_cycles", stb_cycles - s0, 5);
      check("stall_reads", reads - r0, 2);
      check("stall_adr_stable", stall_adr_bad, 0);
      check("stall_consumed", stall_req - stall_done, 0);
      check("stall_push", valid_cnt - v0, 1);

      // FIFO back-pressure in PUSH, plus a start while busy
      fifo_ready = 1'b0; base_addr = 32'h1008;
      d0 = done_cnt; r0 = reads; v0 = valid_cnt;
      exp_q.push_back(48'h000002_000001);
      pulse_start();
      repeat (5) tick();
      base_addr = 32'h1000;
      pulse_start();
      repeat (9) tick();
      check("bp_no_push", valid_cnt - v0, 0);
      check("bp_no_extra_reads", reads - r0, 2);
      check("bp_busy", busy, 1);
      fifo_ready = 1'b1;
      wait_done("backpressure", d0, 20);
      check("bp_one_push", valid_cnt - v0, 1);
      check("bp_reads_total", reads - r0, 2);
      check("bp_frames_done", frames_done, 1);

      // Bus error on right word of the second frame
      err_addr = 32'h100C; base_addr = 32'h1000; num_frames = 2;
      d0 = done_cnt; v0 = valid_cnt;
      exp_q.push_back(48'h112233_AABBCC);
      pulse_start();
      wait_done("buserr", d0, 60);
      check("err_flag", error, 1);
      check("err_pushes", valid_cnt - v0, 1);
      check("err_frames_done", frames_done, 1);
      check("err_done", done_cnt - d0, 1);
      err_addr = 32'hFFFF_FFFC; base_addr = 32'h1008; num_frames = 1;
      d0 = done_cnt;
      exp_q.push_back(48'h000002_000001);
      pulse_start();
      check("err_cleared_on_start", error, 0);
      wait_done("after_err", d0, 60);

      // Watchdog timeout
      no_ack = 1'b1; base_addr = 32'h1000;
      d0 = done_cnt; v0 = valid_cnt; w0 = wait_cycles;
      pulse_start();
      wait_done("timeout", d0, 40);
      check("to_wait_cycles", wait_cycles - w0, 8);
      check("to_error", error, 1);
      check("to_no_push", valid_cnt - v0, 0);
      no_ack = 1'b0;

      // Loop mode, single frame, then abort in REQ_L
      loop_en = 1'b1; base_addr = 32'h1000; num_frames = 1;
      d0 = done_cnt; r0 = reads; v0 = valid_cnt;
      repeat (3) exp_q.push_back(48'h112233_AABBCC);
      pulse_start();
      for (int i = 0; i < 60 && (valid_cnt - v0) < 3; i++) tick();
      check("loop_pushes", valid_cnt - v0, 3);
      check("loop_restart_adr", {wbm_stb_o, wbm_adr_o}, {1'b1, 32'h1000});
      check("loop_frames_done", frames_done, 0);
      abort = 1'b1;
      #1;
      check("abort_req_no_stb", wbm_stb_o, 0);
      tick();
      abort = 1'b0;
      wait_done("loop_abort", d0, 10);
      loop_en = 1'b0;
      check("loop_total_pushes", valid_cnt - v0, 3);
      check("loop_reads", reads - r0, 6);
      check("loop_no_error", error, 0);

      // Abort while waiting for the left ack
      ack_delay = 3; base_addr = 32'h1000;
      d0 = done_cnt; v0 = valid_cnt;
      pulse_start();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_cyc_held", {wbm_cyc_o, wbm_stb_o}, 2'b10);
      wait_done("abort_wait", d0, 40);
      check("abort_no_push", valid_cnt - v0, 0);
      check("abort_done", done_cnt - d0, 1);
      check("abort_idle", busy, 0);

      // Reset in the middle of WAIT_R
      pulse_start();
      repeat (7) tick();
      check("wait_r_state", {wbm_cyc_o, wbm_stb_o, wbm_adr_o}, {2'b10, 32'h1004});
      #1 rst = 1'b0;
      #1;
      check("rst_mid_outputs", {wbm_cyc_o, wbm_stb_o, busy}, 0);
      repeat (2) tick();
      check("rst_mid_audio", audio_data, 0);
      check("rst_mid_frames", frames_done, 0);
      rst = 1'b1;
      ack_delay = 0;
      tick();

      // Zero-frame start: done pulse, no bus activity
      num_frames = 0; r0 = reads;
      pulse_start();
      check("zero_done", {done, busy, wbm_cyc_o}, 3'b110);
      tick();
      check("zero_idle", {done, busy}, 0);
      check("zero_reads", reads - r0, 0);

      repeat (3) tick();
      check("protocol_cyc_hold", cyc_drop_bad, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/audio_wb_dma_reader.md
Name: audio_wb_dma_reader

Overview:
- Wishbone initiator that fetches stereo audio frames from memory and pushes them into the audio FIFO.
- Replaces CPU writes to AUDIO_LEFT/AUDIO_RIGHT. Drives the same 48-bit audio_data/audio_valid/fifo_ready interface that the audio register file drives.
- Sits between the SoC bus interconnect (master port) and the audio FIFO. Software-visible control arrives as plain ports from a separate register block.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for ack/err after a request is accepted; 0 disables the watchdog.
- FRAME_CNT_BITS, 16, width of the frame counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a transfer, honoured only in IDLE
- abort  in  1  stop at the next safe point
- loop_en  in  1  on completion, reload and restart instead of finishing
- base_addr  in  32  byte address of first frame; bits 1:0 ignored
- num_frames  in  FRAME_CNT_BITS  frames per pass
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of a non-looping pass or on abort completion
- error  out  1  sticky; bus error or timeout seen
- frames_done  out  FRAME_CNT_BITS  frames pushed in the current pass
- wbm_adr_o  out  32  byte address
- wbm_dat_i  in  32  read data
- wbm_sel_o  out  4  constant 4'hF
- wbm_we_o  out  1  constant 0
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_stall_i  in  1  pipelined stall
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- audio_data  out  48  [23:0] left, [47:24] right
- audio_valid  out  1  one-cycle push strobe
- fifo_ready  in  1  FIFO accepts a push this cycle

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; all outputs 0 (audio_data included); internal address and counters 0.
- Memory frame layout: two words, left at A, right at A+4, sample in bits 23:0, bits 31:24 ignored. Next frame at A+8. Address wraps modulo 2^32.
- FSM states: IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, PUSH, DONE.
- IDLE:
  - start with num_frames != 0: latch {base_addr[31:2],2'b00} and num_frames, clear error and frames_done, go REQ_L.
  - start with num_frames == 0: pulse done next cycle, no bus activity.
- REQ_x: cyc=stb=1, adr = cur or cur+4. Stay while wbm_stall_i; on a cycle with stall=0, go WAIT_x with stb=0, cyc=1.
- WAIT_x:
  - ack: capture wbm_dat_i[23:0] into the left/right holding register; cyc drops the following cycle (one idle cycle between words).
  - err (priority over ack in the same cycle), or watchdog expiry after TIMEOUT_CYCLES cycles: set error, drop cyc, go DONE with no push.
- PUSH: when fifo_ready, audio_valid=1 for exactly one cycle with audio_data={right,left}, frames_done increments, address += 8. Wait indefinitely while fifo_ready=0.
- After a push:
  - remaining frames: REQ_L.
  - last frame with loop_en=1: reload base_addr, clear frames_done, REQ_L.
  - last frame with loop_en=0: DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls with the transition to IDLE.
- abort:
  - Registered as pending.
  - Never drops cyc while a request is outstanding (after stb accepted, before ack/err).
  - Acted on only in REQ_L before stb is accepted, or at PUSH entry. Pending abort skips the push; go DONE.
  - Pending abort is cleared in IDLE.
- start while busy: ignored.
- Minimum latency, zero stall/wait: start to audio_valid = 6 cycles (REQ_L, WAIT_L, REQ_R, WAIT_R, PUSH, plus the idle cycle absorbed in REQ_R).
- Reset mid-transfer: all outputs drop immediately, including cyc. The interconnect must tolerate this.

Decomposition:
- Shared audio package:
  - FSM state encoding.
  - Frame stride constant (8) and channel offset constant (4).
  - Sample width constant (24).
  - Field positions of audio_data, shared with the audio register file.
- Sub-module: audio_wb_watchdog (load, enable, expired). The rest stays in one module.

Test Plan:
- base_addr=0x1000, num_frames=2, zero-wait memory with words 0x00AABBCC/0x00112233 at 0x1000/0x1004 and 0x00000001/0x00000002 at 0x1008/0x100C -> audio_data 0x112233AABBCC, then 0x000002000001; frames_done=2; one done pulse; busy low afterward.
- wbm_stall_i high 3 cycles on the first request -> stb held 4 cycles, adr stable at 0x1000, single ack accepted, correct data.
- fifo_ready low 10 cycles at PUSH -> audio_valid withheld, then exactly one pulse; no extra bus reads issued meanwhile.
- wbm_err_i on the right-word read of frame 1 -> error=1, no audio_valid for that frame, done pulse, next start clears error.
- TIMEOUT_CYCLES=8 with no ack -> cyc dropped 8 cycles after stb accepted, error=1; loop_en=1 with num_frames=1 -> address returns to base_addr, frames_done resets to 0, continuous pushes.
- abort asserted during WAIT_L -> cyc held until ack, no push, done pulse, IDLE; rst low mid-WAIT_R -> cyc/stb/busy 0 immediately.
